axil_uart_regs: RTL and testbench
=================================

# axil_uart_regs

AXI4-Lite slave register front-end for the UART core. Translates 32-bit register reads/writes from the bus into the UART's byte-level handshakes: pops received bytes (`rd_uart_en`), pushes bytes to transmit (`wr_uart_en`), drives the RX/TX enables, and exposes status, sticky error flags and a level interrupt. It sits directly upstream of `UART` and directly downstream of the system interconnect.

## Interface
- `C_ADDR_WIDTH`, 4: AXI address width. Decode uses bits [3:2]. Bits [1:0] and bits above 3 are ignored, so higher addresses alias.
- `Clk` in 1: single clock for bus and UART side.
- `Reset` in 1: asynchronous, active-high reset.
- `S_AXI_AWADDR` in C_ADDR_WIDTH, `S_AXI_AWVALID` in 1, `S_AXI_AWREADY` out 1: write address channel.
- `S_AXI_WDATA` in 32, `S_AXI_WSTRB` in 4, `S_AXI_WVALID` in 1, `S_AXI_WREADY` out 1: write data channel.
- `S_AXI_BRESP` out 2, `S_AXI_BVALID` out 1, `S_AXI_BREADY` in 1: write response channel.
- `S_AXI_ARADDR` in C_ADDR_WIDTH, `S_AXI_ARVALID` in 1, `S_AXI_ARREADY` out 1: read address channel.
- `S_AXI_RDATA` out 32, `S_AXI_RRESP` out 2, `S_AXI_RVALID` out 1, `S_AXI_RREADY` in 1: read data channel.
- `RX_data` in 8: head received byte from the UART; valid when `Empty`=0.
- `Empty` in 1, `Full` in 1, `Overrun` in 1, `Frame_error` in 1: UART status inputs. `Overrun` and `Frame_error` are 1-cycle pulses.
- `rd_uart_en` out 1: 1-cycle pop pulse to the UART.
- `TX_data` out 8, `wr_uart_en` out 1: byte to transmit and its 1-cycle push pulse.
- `Enable_rx` out 1, `Enable_tx` out 1: UART enables driven from CTRL.
- `irq` out 1: level interrupt.

## Operation
Register map (word offsets):
- **0x0 RXDATA (RO):** returns `{23'b0, valid, byte}`.
  - If `Empty`=0 at AR handshake: valid=1, byte=`RX_data`, and `rd_uart_en` pulses.
  - If `Empty`=1: returns 0x0000_0000 and no pop.
- **0x4 TXDATA (WO):**
  - If `WSTRB[0]`=1 and `Full`=0: `TX_data`=`WDATA[7:0]` and `wr_uart_en` pulses. Response is OKAY.
  - If `Full`=1: byte is dropped and BRESP=SLVERR (2'b10).
  - If `WSTRB[0]`=0: no push, OKAY.
  - A read of TXDATA returns 0 with OKAY.
- **0x8 STATUS (RO):**
  - bit0 = `Empty`, bit1 = `Full`.
  - bit2 = sticky overrun, bit3 = sticky frame error.
  - Writes are ignored with OKAY.
- **0xC CTRL (RW, byte0 strobe):**
  - bit0 rx_en (drives `Enable_rx`), bit1 tx_en (drives `Enable_tx`).
  - bit2 rx_irq_en, bit3 tx_irq_en.
  - bit4 clear_err: write-1 self-clearing pulse that zeroes both sticky bits. Reads as 0.
- **Sticky errors:** set on the input pulse. If a set and a clear occur in the same cycle, set wins.
- **irq** = (rx_irq_en & ~`Empty`) | (tx_irq_en & ~`Full`) | sticky overrun | sticky frame error. Registered, so it lags its inputs by 1 cycle.
- **Write FSM** (W_IDLE, W_RESP):
  - In W_IDLE, AW and W are latched independently. `AWREADY`=1 while no address is held; `WREADY`=1 while no data is held.
  - Once both are held: perform the register action, assert `BVALID`, go to W_RESP.
  - In W_RESP: hold `BVALID`/`BRESP` until `BREADY`, then clear the holds and return to W_IDLE. `AWREADY`=`WREADY`=0 in W_RESP.
- **Read FSM** (R_IDLE, R_DATA):
  - R_IDLE: `ARREADY`=1. On AR handshake, capture `RDATA`/`RRESP` (including any pop decision) and go to R_DATA.
  - R_DATA: `ARREADY`=0; hold `RVALID`, `RDATA`, `RRESP` until `RREADY`, then return to R_IDLE.
- Read and write channels are fully independent. A simultaneous RXDATA read and TXDATA write both take effect in the same cycle.
- No unmapped addresses exist, because all four offsets decode.

## Timing
- **Reset values:**
  - All READY, VALID and pulse outputs 0; `BRESP`=`RRESP`=0; `RDATA`=0; `TX_data`=0.
  - `Enable_rx`=`Enable_tx`=0; irq enables and sticky bits 0; `irq`=0.
  - Both FSMs in IDLE; AW/W holds empty.
- **Write latency:** if the later of the AW/W handshakes completes in cycle N, then in N+1 the register updates, `wr_uart_en` pulses for exactly one cycle with `TX_data` valid that cycle, and `BVALID`=1. `Full` is sampled in cycle N.
- **Read latency:** AR handshake in cycle N. `rd_uart_en` pulses in N, with `RX_data` sampled in N. `RVALID`=1 from N+1.
- **Throughput:** one transaction per 2 cycles per channel when READY is held high.
- **Reset mid-transaction:** asynchronous Reset aborts any in-flight AXI response and returns all state to reset values. No pop or push pulse may be emitted in the cycle after reset deassertion.

## Test plan
- **Reset and idle:** Reset=1, then release → all outputs 0, `AWREADY`=`WREADY`=`ARREADY`=1, `BVALID`=`RVALID`=0.
- **TX push:** write 0x0000_00A5 to 0x4 with `Full`=0 → one `wr_uart_en` pulse with `TX_data`=0xA5, BRESP=00. Repeat with `Full`=1 → no pulse, BRESP=10.
- **RX pop:** `Empty`=0, `RX_data`=0x3C, read 0x0 → `RDATA`=0x0000_013C and one `rd_uart_en` pulse. Repeat with `Empty`=1 → `RDATA`=0, no pulse.
- **AW/W skew:** AW issued 3 cycles before W → `AWREADY` drops after its handshake, write completes 1 cycle after the W handshake. `BREADY` held low for 4 cycles → `BVALID` stays 1 and `AWREADY`=0 throughout.
- **Sticky errors:**
  - Pulse `Overrun` → STATUS reads 0x4.
  - Write CTRL=0x10 in the same cycle as a `Frame_error` pulse → STATUS reads 0x8 (set wins over clear).
  - Write CTRL=0x10 again → STATUS reads 0x0.
- **CTRL and irq:**
  - Write CTRL=0x07 → `Enable_rx`=`Enable_tx`=1; `irq` follows `~Empty` one cycle late.
  - Write with `WSTRB`=0 → CTRL unchanged.
  - Issue a concurrent RXDATA read and TXDATA write → both pulses occur in their specified cycles.

Source files
------------

// File: rtl/axil_uart_regs_if.sv
// rtl/axil_uart_regs_if.sv - AXI4-Lite bus bundle for the UART register front-end
interface axil_uart_regs_if #(
  parameter int C_ADDR_WIDTH = 4
);
  logic [C_ADDR_WIDTH-1:0] awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [31:0]             wdata;
  logic [3:0]              wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [C_ADDR_WIDTH-1:0] araddr;
  logic                    arvalid;
  logic                    arready;
  logic [31:0]             rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_uart_regs.sv
// rtl/axil_uart_regs.sv - AXI4-Lite register front-end turning word accesses into UART byte handshakes
module axil_uart_regs (
  input  logic             Clk,
  input  logic             Reset,
  axil_uart_regs_if.slave  s_axi,
  input  logic [7:0]       RX_data,
  input  logic             Empty,
  input  logic             Full,
  input  logic             Overrun,
  input  logic             Frame_error,
  output logic             rd_uart_en,
  output logic [7:0]       TX_data,
  output logic             wr_uart_en,
  output logic             Enable_rx,
  output logic             Enable_tx,
  output logic             irq
);
  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t    w_state, w_next;
  r_state_t    r_state, r_next;

  // Held low for the first cycle after reset so no handshake (and no pulse) can occur then.
  logic        ready_en;

  logic        aw_held, w_held;
  logic [1:0]  aw_addr_q;
  logic [7:0]  w_data_q;
  logic        w_strb0_q;

  logic        awready, wready, bvalid, arready, rvalid;
  logic        aw_hs, w_hs, ar_hs, do_write;
  logic [1:0]  wr_addr, rd_addr;
  logic [7:0]  wr_data;
  logic        wr_strb0;
  logic        tx_push, ctrl_we, clear_err;
  logic        rx_irq_en, tx_irq_en, sticky_ov, sticky_fe;
  logic [1:0]  bresp_q;
  logic [31:0] rdata_q, rd_word;
  logic        unused_axi;

  assign unused_axi = ^{s_axi.awaddr, s_axi.araddr, s_axi.wdata, s_axi.wstrb};

  assign awready = ready_en & (w_state == W_IDLE) & ~aw_held;
  assign wready  = ready_en & (w_state == W_IDLE) & ~w_held;
  assign arready = ready_en & (r_state == R_IDLE);
  assign aw_hs   = s_axi.awvalid & awready;
  assign w_hs    = s_axi.wvalid & wready;
  assign ar_hs   = s_axi.arvalid & arready;

  // Bus values bypass the holds so the action fires in the cycle of the later handshake.
  assign wr_addr  = aw_held ? aw_addr_q : s_axi.awaddr[3:2];
  assign wr_data  = w_held ? w_data_q : s_axi.wdata[7:0];
  assign wr_strb0 = w_held ? w_strb0_q : s_axi.wstrb[0];

  assign tx_push   = do_write & (wr_addr == 2'd1) & wr_strb0 & ~Full;
  assign ctrl_we   = do_write & (wr_addr == 2'd3) & wr_strb0;
  assign clear_err = ctrl_we & wr_data[4];

  assign rd_addr    = s_axi.araddr[3:2];
  assign rd_uart_en = ar_hs & (rd_addr == 2'd0) & ~Empty;

  assign s_axi.awready = awready;
  assign s_axi.wready  = wready;
  assign s_axi.bvalid  = bvalid;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready;
  assign s_axi.rvalid  = rvalid;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = 2'b00;

  always_comb begin
    w_next   = w_state;
    bvalid   = 1'b0;
    do_write = 1'b0;
    case (w_state)
      W_IDLE: begin
        if ((aw_held | aw_hs) & (w_held | w_hs)) begin
          do_write = 1'b1;
          w_next   = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (s_axi.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    rvalid = 1'b0;
    case (r_state)
      R_IDLE: if (ar_hs) r_next = R_DATA;
      R_DATA: begin
        rvalid = 1'b1;
        if (s_axi.rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    case (rd_addr)
      2'd0:    rd_word = Empty ? 32'd0 : {23'd0, 1'b1, RX_data};
      2'd2:    rd_word = {28'd0, sticky_fe, sticky_ov, Full, Empty};
      2'd3:    rd_word = {28'd0, tx_irq_en, rx_irq_en, Enable_tx, Enable_rx};
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      w_state    <= W_IDLE;
      r_state    <= R_IDLE;
      ready_en   <= 1'b0;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb0_q  <= 1'b0;
      bresp_q    <= 2'b00;
      rdata_q    <= '0;
      wr_uart_en <= 1'b0;
      TX_data    <= '0;
      Enable_rx  <= 1'b0;
      Enable_tx  <= 1'b0;
      rx_irq_en  <= 1'b0;
      tx_irq_en  <= 1'b0;
      sticky_ov  <= 1'b0;
      sticky_fe  <= 1'b0;
      irq        <= 1'b0;
    end else begin
      w_state  <= w_next;
      r_state  <= r_next;
      ready_en <= 1'b1;

      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axi.awaddr[3:2];
      end else if (bvalid & s_axi.bready) begin
        aw_held <= 1'b0;
      end
      if (w_hs) begin
        w_held    <= 1'b1;
        w_data_q  <= s_axi.wdata[7:0];
        w_strb0_q <= s_axi.wstrb[0];
      end else if (bvalid & s_axi.bready) begin
        w_held <= 1'b0;
      end

      if (do_write) bresp_q <= ((wr_addr == 2'd1) && wr_strb0 && Full) ? 2'b10 : 2'b00;
      wr_uart_en <= tx_push;
      if (tx_push) TX_data <= wr_data;

      if (ctrl_we) begin
        Enable_rx <= wr_data[0];
        Enable_tx <= wr_data[1];
        rx_irq_en <= wr_data[2];
        tx_irq_en <= wr_data[3];
      end

      // A new error pulse wins over a clear landing in the same cycle.
      sticky_ov <= Overrun | (sticky_ov & ~clear_err);
      sticky_fe <= Frame_error | (sticky_fe & ~clear_err);

      irq <= (rx_irq_en & ~Empty) | (tx_irq_en & ~Full) | sticky_ov | sticky_fe;

      if (ar_hs) rdata_q <= rd_word;
    end
  end
endmodule

// File: tb/tb_axil_uart_regs.sv
// tb/tb_axil_uart_regs.sv - directed bench for the AXI4-Lite UART register front-end
module tb_axil_uart_regs;
  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] RX_data = '0;
  logic       Empty = 1'b1;
  logic       Full = 1'b0;
  logic       Overrun = 1'b0;
  logic       Frame_error = 1'b0;
  logic       rd_uart_en, wr_uart_en, Enable_rx, Enable_tx, irq;
  logic [7:0] TX_data;

  int n_checks = 0;
  int n_pass = 0;
  int n_push = 0;
  int n_pop = 0;
  logic [7:0] last_tx = '0;

  axil_uart_regs_if #(.C_ADDR_WIDTH(4)) s ();

  axil_uart_regs dut (
    .Clk(Clk), .Reset(Reset), .s_axi(s),
    .RX_data(RX_data), .Empty(Empty), .Full(Full), .Overrun(Overrun), .Frame_error(Frame_error),
    .rd_uart_en(rd_uart_en), .TX_data(TX_data), .wr_uart_en(wr_uart_en),
    .Enable_rx(Enable_rx), .Enable_tx(Enable_tx), .irq(irq)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (wr_uart_en) begin
      n_push++;
      last_tx = TX_data;
    end
    if (rd_uart_en) n_pop++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    logic aw_go, w_go;
    int t;
    resp = 2'b11;
    s.awaddr = addr; s.awvalid = 1'b1;
    s.wdata = data; s.wstrb = strb; s.wvalid = 1'b1;
    s.bready = 1'b1;
    t = 0;
    while ((s.awvalid || s.wvalid) && t < 20) begin
      @(negedge Clk);
      aw_go = s.awvalid & s.awready;
      w_go  = s.wvalid & s.wready;
      tick();
      if (aw_go) s.awvalid = 1'b0;
      if (w_go) s.wvalid = 1'b0;
      t++;
    end
    s.awvalid = 1'b0;
    s.wvalid = 1'b0;
    t = 0;
    @(negedge Clk);
    while (!s.bvalid && t < 20) begin
      @(negedge Clk);
      t++;
    end
    if (!s.bvalid) check("write_timeout", 32'd0, 32'd1);
    else resp = s.bresp;
    tick();
    s.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    logic ar_go;
    int t;
    data = 32'hDEAD_BEEF;
    s.araddr = addr; s.arvalid = 1'b1; s.rready = 1'b1;
    ar_go = 1'b0;
    t = 0;
    while (!ar_go && t < 20) begin
      @(negedge Clk);
      ar_go = s.arready;
      tick();
      t++;
    end
    s.arvalid = 1'b0;
    t = 0;
    @(negedge Clk);
    while (!s.rvalid && t < 20) begin
      @(negedge Clk);
      t++;
    end
    if (!s.rvalid) check("read_timeout", 32'd0, 32'd1);
    else data = s.rdata;
    tick();
    s.rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int p0, r0;

    s.awaddr = '0; s.awvalid = 0; s.wdata = '0; s.wstrb = '0; s.wvalid = 0; s.bready = 0;
    s.araddr = '0; s.arvalid = 0; s.rready = 0;

    // Reset and idle
    @(negedge Clk);
    check("reset_ctrl_bits",
          {22'd0, s.awready, s.wready, s.arready, s.bvalid, s.rvalid, wr_uart_en, rd_uart_en,
           Enable_rx, Enable_tx, irq}, 32'd0);
    check("reset_data", {s.rdata[15:0], TX_data, 2'b0, s.bresp, 2'b0, s.rresp}, 32'd0);
    tick();
    Reset = 1'b0;
    tick();
    @(negedge Clk);
    check("idle_ready", {29'd0, s.awready, s.wready, s.arready}, 32'h7);
    check("idle_valid", {30'd0, s.bvalid, s.rvalid}, 32'd0);

    // TX push, then dropped byte when full
    tick();
    p0 = n_push;
    axi_write(4'h4, 32'h0000_00A5, 4'hF, resp);
    check("tx_bresp_ok", resp, 2'b00);
    check("tx_push_count", n_push - p0, 1);
    check("tx_data", last_tx, 8'hA5);
    Full = 1'b1;
    p0 = n_push;
    axi_write(4'h4, 32'h0000_0011, 4'hF, resp);
    check("tx_full_slverr", resp, 2'b10);
    check("tx_full_no_push", n_push - p0, 0);
    Full = 1'b0;

    // RX pop, then empty read
    Empty = 1'b0; RX_data = 8'h3C;
    r0 = n_pop;
    axi_read(4'h0, rd);
    check("rx_rdata", rd, 32'h0000_013C);
    check("rx_pop_count", n_pop - r0, 1);
    Empty = 1'b1;
    r0 = n_pop;
    axi_read(4'h0, rd);
    check("rx_empty_rdata", rd, 32'd0);
    check("rx_empty_no_pop", n_pop - r0, 0);

    // AW three cycles ahead of W, BREADY held off
    p0 = n_push;
    s.awaddr = 4'h4; s.awvalid = 1'b1; s.bready = 1'b0;
    @(negedge Clk);
    check("skew_awready_pre", s.awready, 1);
    tick();
    s.awvalid = 1'b0;
    @(negedge Clk);
    check("skew_awready_drop", s.awready, 0);
    tick();
    tick();
    s.wdata = 32'h0000_005A; s.wstrb = 4'h1; s.wvalid = 1'b1;
    @(negedge Clk);
    check("skew_wready", s.wready, 1);
    check("skew_no_bvalid_yet", s.bvalid, 0);
    tick();
    s.wvalid = 1'b0;
    @(negedge Clk);
    check("skew_push_cycle", {wr_uart_en, TX_data}, {1'b1, 8'h5A});
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check($sformatf("skew_hold_%0d", i), {s.bvalid, s.awready}, 2'b10);
      tick();
    end
    s.bready = 1'b1;
    tick();
    s.bready = 1'b0;
    @(negedge Clk);
    check("skew_released", {s.bvalid, s.awready}, 2'b01);
    check("skew_push_count", n_push - p0, 1);
    tick();

    // Sticky errors
    Empty = 1'b0;
    Overrun = 1'b1;
    tick();
    Overrun = 1'b0;
    axi_read(4'h8, rd);
    check("sticky_overrun", rd, 32'h4);
    s.awaddr = 4'hC; s.awvalid = 1'b1; s.wdata = 32'h10; s.wstrb = 4'h1; s.wvalid = 1'b1;
    s.bready = 1'b1; Frame_error = 1'b1;
    @(negedge Clk);
    check("clear_hs_ready", {s.awready, s.wready}, 2'b11);
    tick();
    s.awvalid = 1'b0; s.wvalid = 1'b0; Frame_error = 1'b0;
    @(negedge Clk);
    check("clear_bvalid", s.bvalid, 1);
    tick();
    s.bready = 1'b0;
    axi_read(4'h8, rd);
    check("sticky_set_wins", rd, 32'h8);
    axi_write(4'hC, 32'h10, 4'h1, resp);
    axi_read(4'h8, rd);
    check("sticky_cleared", rd, 32'h0);

    // CTRL, enables and irq
    axi_write(4'hC, 32'h07, 4'h1, resp);
    check("ctrl_enables", {Enable_rx, Enable_tx}, 2'b11);
    axi_read(4'hC, rd);
    check("ctrl_readback", rd, 32'h07);
    @(negedge Clk);
    check("irq_on", irq, 1);
    tick();
    Empty = 1'b1;
    @(negedge Clk);
    check("irq_lag_fall", irq, 1);
    tick();
    @(negedge Clk);
    check("irq_fell", irq, 0);
    tick();
    Empty = 1'b0;
    @(negedge Clk);
    check("irq_lag_rise", irq, 0);
    tick();
    @(negedge Clk);
    check("irq_rose", irq, 1);
    tick();
    axi_write(4'hC, 32'h00, 4'h0, resp);
    check("ctrl_nostrb_resp", resp, 2'b00);
    axi_read(4'hC, rd);
    check("ctrl_nostrb_kept", rd, 32'h07);

    // Concurrent RXDATA read and TXDATA write
    Empty = 1'b0; RX_data = 8'h77; Full = 1'b0;
    p0 = n_push; r0 = n_pop;
    s.araddr = 4'h0; s.arvalid = 1'b1; s.rready = 1'b1;
    s.awaddr = 4'h4; s.awvalid = 1'b1; s.wdata = 32'h99; s.wstrb = 4'h1; s.wvalid = 1'b1;
    s.bready = 1'b1;
    @(negedge Clk);
    check("conc_cycle_n", {rd_uart_en, wr_uart_en}, 2'b10);
    tick();
    s.arvalid = 1'b0; s.awvalid = 1'b0; s.wvalid = 1'b0;
    @(negedge Clk);
    check("conc_cycle_n1", {rd_uart_en, wr_uart_en, s.rvalid, s.bvalid}, 4'b0111);
    check("conc_rdata", s.rdata, 32'h0000_0177);
    check("conc_tx", TX_data, 8'h99);
    tick();
    s.rready = 1'b0; s.bready = 1'b0;
    check("conc_counts", {n_push - p0, n_pop - r0}, {32'd1, 32'd1});
    Empty = 1'b1;

    // Reset during a pending read response
    s.araddr = 4'h8; s.arvalid = 1'b1; s.rready = 1'b0;
    tick();
    s.arvalid = 1'b0;
    @(negedge Clk);
    check("mid_rvalid", s.rvalid, 1);
    #1 Reset = 1'b1;
    #1;
    check("mid_reset_abort", {s.rvalid, Enable_rx, Enable_tx}, 3'b000);
    s.araddr = 4'h0; s.arvalid = 1'b1; Empty = 1'b0; s.rready = 1'b1;
    r0 = n_pop;
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    check("post_reset_no_pop", {rd_uart_en, s.arready}, 2'b00);
    tick();
    s.arvalid = 1'b0;
    @(negedge Clk);
    check("post_reset_ready", s.arready, 1);
    check("post_reset_pop_count", n_pop - r0, 0);
    tick();
    s.rready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end
endmodule
